exp_mask_mem_wr: RTL and testbench
==================================

EXP_MASK_MEM_WR -- requirements
Module: exp_mask_mem_wr

Interface
REQ-001 Parameter: EXP_VLD_SAMPLES, default 4, coefficients per input beat.
REQ-002 Parameter: EXP_VLD_SAMPLE_W, default 24, bits per coefficient.
REQ-003 Parameter: MEM_ADDR_W, default 14, memory word address width.
REQ-004 Parameter: COEFF_CNT, default 256, coefficients per polynomial; SHALL be a multiple of EXP_VLD_SAMPLES.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  in  1  block clock.
REQ-007 Port: rst_b  in  1  asynchronous active-low reset.
REQ-008 Port: zeroize  in  1  synchronous clear of all state.
REQ-009 Port: en_i  in  1  start pulse; arms one polynomial write.
REQ-010 Port: base_addr_i  in  MEM_ADDR_W  destination word address, sampled on accepted en_i.
REQ-011 Port: data_valid_i  in  1  beat valid from the mask sampler; no backpressure exists.
REQ-012 Port: data_i  in  EXP_VLD_SAMPLES*EXP_VLD_SAMPLE_W  packed coefficients, lane 0 at LSBs.
REQ-013 Port: mem_we_o  out  1  memory write enable.
REQ-014 Port: mem_addr_o  out  MEM_ADDR_W  memory write address.
REQ-015 Port: mem_wdata_o  out  EXP_VLD_SAMPLES*EXP_VLD_SAMPLE_W  memory write data.
REQ-016 Port: busy_o  out  1  high in WRITE state.
REQ-017 Port: done_o  out  1  one-cycle pulse after the last beat is written.
REQ-018 Port: error_o  out  1  sticky; a beat arrived while not in WRITE.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, DONE; reset and zeroize state is IDLE.
REQ-020 IDLE: en_i=1 SHALL capture base_addr_i, clear beat counter, clear error_o, and move to WRITE next cycle.
REQ-021 WRITE: each cycle with data_valid_i=1 SHALL accept one beat; no beat is ever stalled or dropped in WRITE.
REQ-022 Accepted beat k (0-based) SHALL produce, on the following clock edge, mem_we_o=1, mem_addr_o=base+k, mem_wdata_o=data_i unmodified; latency exactly 1 cycle.
REQ-023 Address addition SHALL wrap modulo 2^MEM_ADDR_W.
REQ-024 mem_we_o SHALL be 0 in every cycle that does not follow an accepted beat; mem_addr_o/mem_wdata_o hold last value.
REQ-025 Beat counter width SHALL be clog2(COEFF_CNT/EXP_VLD_SAMPLES); on acceptance of beat COEFF_CNT/EXP_VLD_SAMPLES-1 FSM SHALL move to DONE.
REQ-026 DONE SHALL last one cycle with done_o=1 (coincident with the last mem_we_o), then move to IDLE.
REQ-027 data_valid_i in IDLE or DONE SHALL be dropped (no write) and set error_o; includes valid coincident with en_i in IDLE.
REQ-028 en_i in WRITE or DONE SHALL be ignored.
REQ-029 zeroize=1 SHALL, at the next edge, return all registers to reset values and suppress any write for a beat presented that cycle; zeroize overrides en_i and data_valid_i.
REQ-030 Gaps of any length between beats SHALL not affect address sequence or count.

Reset
REQ-031 On rst_b=0, asynchronously: state IDLE, counter 0, base 0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, error_o=0.
REQ-032 Reset mid-WRITE SHALL abandon the polynomial; no further writes until a new en_i.

Verification
REQ-033 en_i with base 0x0100, 64 back-to-back beats (data = beat index replicated per lane) -> writes to 0x0100..0x013F in order, each one cycle after its beat, done_o on cycle of write 0x013F, error_o=0.
REQ-034 Same with random 0-5 cycle gaps between beats -> identical address/data sequence, exactly 64 writes, single done_o pulse.
REQ-035 base 0x3FF0, 64 beats -> addresses 0x3FF0..0x3FFF then 0x0000..0x002F.
REQ-036 Beat in IDLE without en_i, and 65th beat after done_o -> no mem_we_o, error_o=1 until next en_i.
REQ-037 zeroize asserted after 30 beats together with a valid beat -> no write for that beat, outputs at reset values next cycle, new en_i then 64 beats completes normally from new base.
REQ-038 rst_b pulsed low after 10 beats -> outputs reset immediately; subsequent full run matches REQ-033.

Source files
------------

// File: rtl/exp_mask_mem_wr.sv
// Writes one polynomial of mask-sampler coefficient beats to consecutive memory words.
// en_i arms the write. Each accepted beat is written one cycle later at base+k. Stray beats set a sticky error.
module exp_mask_mem_wr #(
    parameter int unsigned EXP_VLD_SAMPLES  = 4,
    parameter int unsigned EXP_VLD_SAMPLE_W = 24,
    parameter int unsigned MEM_ADDR_W       = 14,
    parameter int unsigned COEFF_CNT        = 256
) (
    input  logic                                         clk,
    input  logic                                         rst_b,
    input  logic                                         zeroize,
    input  logic                                         en_i,
    input  logic [MEM_ADDR_W-1:0]                        base_addr_i,
    input  logic                                         data_valid_i,
    input  logic [EXP_VLD_SAMPLES*EXP_VLD_SAMPLE_W-1:0]  data_i,
    output logic                                         mem_we_o,
    output logic [MEM_ADDR_W-1:0]                        mem_addr_o,
    output logic [EXP_VLD_SAMPLES*EXP_VLD_SAMPLE_W-1:0]  mem_wdata_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         error_o
);
    localparam int unsigned DW    = EXP_VLD_SAMPLES * EXP_VLD_SAMPLE_W;
    localparam int unsigned BEATS = COEFF_CNT / EXP_VLD_SAMPLES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [MEM_ADDR_W-1:0]  base_q;
    logic                   mem_we_q;
    logic [MEM_ADDR_W-1:0]  mem_addr_q;
    logic [DW-1:0]          mem_wdata_q;
    logic                   error_q;
    logic [MEM_ADDR_W-1:0]  addr_d;

    // Natural-width addition gives the modulo-2^MEM_ADDR_W wrap.
    assign addr_d = base_q + MEM_ADDR_W'(cnt_q);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else if (zeroize) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        base_q  <= base_addr_i;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                        state_q <= WRITE;
                    end
                    // A beat coincident with en_i is still an error: it sets after the clear.
                    if (data_valid_i) error_q <= 1'b1;
                end
                WRITE: begin
                    if (data_valid_i) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= data_i;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (data_valid_i) error_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q == WRITE);
    assign done_o      = (state_q == DONE);
    assign error_o     = error_q;

endmodule

// File: tb/tb_exp_mask_mem_wr.sv
// Directed bench for exp_mask_mem_wr: a vector table plus full-polynomial sequences.
// The sequences cover gaps, address wrap, stray beats, zeroize and async reset.
module tb_exp_mask_mem_wr;
    localparam int unsigned N     = 4;
    localparam int unsigned SW    = 24;
    localparam int unsigned AW    = 14;
    localparam int unsigned CC    = 256;
    localparam int unsigned DW    = N * SW;
    localparam int unsigned BEATS = CC / N;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          zeroize;
    logic          en_i;
    logic [AW-1:0] base_addr_i;
    logic          data_valid_i;
    logic [DW-1:0] data_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    exp_mask_mem_wr #(
        .EXP_VLD_SAMPLES (N),
        .EXP_VLD_SAMPLE_W(SW),
        .MEM_ADDR_W      (AW),
        .COEFF_CNT       (CC)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .zeroize     (zeroize),
        .en_i        (en_i),
        .base_addr_i (base_addr_i),
        .data_valid_i(data_valid_i),
        .data_i      (data_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    typedef struct {
        logic          en;
        logic [AW-1:0] base;
        logic          vld;
        logic [DW-1:0] data;
        logic          zer;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          busy;
        logic          done;
        logic          err;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic busy, input logic done,
                              input logic err);
        logic [DW+AW+3:0] act, exp;
        act = {mem_we_o, busy_o, done_o, error_o, mem_addr_o, mem_wdata_o};
        exp = {we, busy, done, err, a, d};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got we=%0b busy=%0b done=%0b err=%0b addr=%h data=%h, want we=%0b busy=%0b done=%0b err=%0b addr=%h data=%h",
                     name, mem_we_o, busy_o, done_o, error_o, mem_addr_o, mem_wdata_o,
                     we, busy, done, err, a, d);
        end
        m_addr = a;
        m_data = d;
    endtask

    task automatic run_poly(input logic [AW-1:0] base, input int unsigned gapmax, input logic late_beat);
        int unsigned g;
        en_i = 1'b1; base_addr_i = base; data_valid_i = 1'b0;
        tick();
        en_i = 1'b0;
        expect_out("start", 1'b0, m_addr, m_data, 1'b1, 1'b0, 1'b0);
        for (int unsigned k = 0; k < BEATS; k++) begin
            g = (gapmax != 0) ? $urandom_range(gapmax, 0) : 0;
            for (int unsigned j = 0; j < g; j++) begin
                data_valid_i = 1'b0;
                tick();
                expect_out("gap", 1'b0, m_addr, m_data, 1'b1, 1'b0, 1'b0);
            end
            data_valid_i = 1'b1;
            data_i = {N{SW'(k)}};
            tick();
            data_valid_i = 1'b0;
            expect_out($sformatf("beat%0d", k), 1'b1, base + AW'(k), {N{SW'(k)}},
                       k != BEATS - 1, k == BEATS - 1, 1'b0);
        end
        // Optional 65th beat lands in the DONE cycle.
        data_valid_i = late_beat;
        data_i = '1;
        tick();
        data_valid_i = 1'b0;
        expect_out("after", 1'b0, m_addr, m_data, 1'b0, 1'b0, late_beat);
    endtask

    initial begin
        rst_b = 1'b0; zeroize = 1'b0; en_i = 1'b0; base_addr_i = '0;
        data_valid_i = 1'b0; data_i = '0;
        m_addr = '0; m_data = '0;

        //           en    base      vld   data          zer   we    addr      wd            busy  done  err
        tbl[0]  = '{1'b0, 14'h0000, 1'b1, DW'(96'hA),  1'b0, 1'b0, 14'h0000, DW'(0),      1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 14'h0100, 1'b0, DW'(0),      1'b0, 1'b0, 14'h0000, DW'(0),      1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 14'h0000, 1'b1, DW'(96'h11), 1'b0, 1'b1, 14'h0100, DW'(96'h11), 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 14'h0000, 1'b0, DW'(0),      1'b0, 1'b0, 14'h0100, DW'(96'h11), 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 14'h2000, 1'b1, DW'(96'h22), 1'b0, 1'b1, 14'h0101, DW'(96'h22), 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 14'h0000, 1'b1, DW'(96'h33), 1'b0, 1'b1, 14'h0102, DW'(96'h33), 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 14'h0000, 1'b1, DW'(96'h44), 1'b1, 1'b0, 14'h0000, DW'(0),      1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 14'h0000, 1'b1, DW'(96'h55), 1'b0, 1'b0, 14'h0000, DW'(0),      1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 14'h3FFF, 1'b0, DW'(0),      1'b0, 1'b0, 14'h0000, DW'(0),      1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 14'h0000, 1'b1, DW'(96'h66), 1'b0, 1'b1, 14'h3FFF, DW'(96'h66), 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 14'h0000, 1'b1, DW'(96'h77), 1'b0, 1'b1, 14'h0000, DW'(96'h77), 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 14'h0000, 1'b0, DW'(0),      1'b1, 1'b0, 14'h0000, DW'(0),      1'b0, 1'b0, 1'b0};

        #12;
        expect_out("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            en_i = tbl[i].en; base_addr_i = tbl[i].base; data_valid_i = tbl[i].vld;
            data_i = tbl[i].data; zeroize = tbl[i].zer;
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd,
                       tbl[i].busy, tbl[i].done, tbl[i].err);
        end
        en_i = 1'b0; data_valid_i = 1'b0; zeroize = 1'b0;

        // Back-to-back, random gaps, and address wrap with a late beat.
        run_poly(14'h0100, 0, 1'b0);
        run_poly(14'h0100, 5, 1'b0);
        run_poly(14'h3FF0, 0, 1'b1);
        data_valid_i = 1'b1; data_i = DW'(96'h99);
        tick();
        data_valid_i = 1'b0;
        expect_out("idle_beat", 1'b0, m_addr, m_data, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("err_sticky", 1'b0, m_addr, m_data, 1'b0, 1'b0, 1'b1);

        // Zeroize after 30 beats, coincident with a valid beat.
        en_i = 1'b1; base_addr_i = 14'h0200;
        tick();
        en_i = 1'b0;
        expect_out("z_start", 1'b0, m_addr, m_data, 1'b1, 1'b0, 1'b0);
        for (int unsigned k = 0; k < 30; k++) begin
            data_valid_i = 1'b1; data_i = {N{SW'(k)}};
            tick();
            expect_out("z_beat", 1'b1, 14'h0200 + AW'(k), {N{SW'(k)}}, 1'b1, 1'b0, 1'b0);
        end
        zeroize = 1'b1; data_i = DW'(96'hBEEF);
        tick();
        zeroize = 1'b0; data_valid_i = 1'b0;
        expect_out("zeroize", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        run_poly(14'h1234, 0, 1'b0);

        // Asynchronous reset after 10 beats.
        en_i = 1'b1; base_addr_i = 14'h0100;
        tick();
        en_i = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            data_valid_i = 1'b1; data_i = {N{SW'(k)}};
            tick();
            expect_out("r_beat", 1'b1, 14'h0100 + AW'(k), {N{SW'(k)}}, 1'b1, 1'b0, 1'b0);
        end
        data_valid_i = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_b = 1'b1;
        data_valid_i = 1'b1; data_i = DW'(96'h5);
        tick();
        data_valid_i = 1'b0;
        expect_out("post_rst_beat", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_poly(14'h0100, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
